// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register between NREQ writers.
// One grant per cycle; the granted slice lands in q on the closing edge.
module reg_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic                  clr,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic [IDW-1:0]        q_owner,
    output logic                  q_valid,
    output logic                  busy
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  w_gnt_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_widx;
    logic [IDW-1:0]   w_ptr_inc;
    logic [IDW-1:0]   w_base;
    logic [IDW-1:0]   w_idx;
    logic [IDW-1:0]   w_sel_idx;
    logic [NREQ-1:0]  w_cand;
    logic [NREQ-1:0]  w_wmask;
    logic             w_found;
    logic [WIDTH-1:0] r_q;
    logic [IDW-1:0]   r_owner;
    logic             r_valid;

    assign w_ptr_inc = (r_widx == IDW'(NREQ - 1)) ? '0 : r_widx + 1'b1;
    assign w_wmask   = NREQ'(1) << r_widx;

    // While granting, the current writer is masked and the search
    // restarts just past it, which keeps back-to-back rotation strict.
    always_comb begin
        w_base = r_ptr;
        w_cand = req;
        if (r_state == S_GRANT) begin
            w_base = w_ptr_inc;
            w_cand = req & ~w_wmask;
        end
    end

    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        w_idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = IDW'((int'(w_base) + i) % NREQ);
            if (!w_found && w_cand[w_idx]) begin
                w_found   = 1'b1;
                w_sel_idx = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        if (!clr && w_found) begin
            w_state_nxt = S_GRANT;
            w_gnt_nxt   = NREQ'(1) << w_sel_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_widx  <= '0;
            r_ptr   <= '0;
            r_q     <= '0;
            r_owner <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            if (w_state_nxt == S_GRANT) begin
                r_widx <= w_sel_idx;
            end
            // A clear on a grant cycle discards that write entirely.
            if (clr) begin
                r_q     <= '0;
                r_owner <= '0;
                r_valid <= 1'b0;
            end else if (r_state == S_GRANT) begin
                r_q     <= wdata[r_widx*WIDTH +: WIDTH];
                r_owner <= r_widx;
                r_valid <= 1'b1;
                r_ptr   <= w_ptr_inc;
            end
        end
    end

    assign gnt     = r_gnt;
    assign q       = r_q;
    assign q_owner = r_owner;
    assign q_valid = r_valid;
    assign busy    = (r_state == S_GRANT);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: expected grants and writes are
// queued by the stimulus and retired by a negedge monitor.
module tb_reg_share_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic        clr;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [1:0]  q_owner;
    logic        q_valid;
    logic        busy;

    typedef struct {
        logic [7:0] d;
        logic [1:0] o;
    } wr_t;

    logic [3:0] exp_gnt[$];
    wr_t        exp_wr[$];
    int         n_vec;
    int         n_err;
    logic       pend;

    reg_share_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wdata   (wdata),
        .clr     (clr),
        .gnt     (gnt),
        .q       (q),
        .q_owner (q_owner),
        .q_valid (q_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_g(input logic [3:0] g);
        exp_gnt.push_back(g);
    endtask

    task automatic push_w(input logic [7:0] d, input logic [1:0] o);
        wr_t e;
        e.d = d;
        e.o = o;
        exp_wr.push_back(e);
    endtask

    initial begin
        wr_t       e;
        logic [3:0] g;
        pend = 1'b0;
        forever begin
            @(negedge clk or negedge reset);
            if (!reset) begin
                pend = 1'b0;
            end else if (!clk) begin
                if (pend) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_write", 32'(q), 32'hFFFF);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("q", 32'(q), 32'(e.d));
                        chk("q_owner", 32'(q_owner), 32'(e.o));
                        chk("q_valid", 32'(q_valid), 32'd1);
                    end
                    pend = 1'b0;
                end
                if (gnt != 4'b0) begin
                    if (exp_gnt.size() == 0) begin
                        chk("unexpected_gnt", 32'(gnt), 32'h0);
                    end else begin
                        g = exp_gnt.pop_front();
                        chk("gnt", 32'(gnt), 32'(g));
                    end
                    chk("busy_in_grant", 32'(busy), 32'd1);
                    pend = !clr;
                end
            end
        end
    end

    initial begin
        clk   = 1'b0;
        reset = 1'b0;
        req   = 4'b1111;
        clr   = 1'b0;
        wdata = 32'h44332211;
        n_vec = 0;
        n_err = 0;

        // reset held with all requests up
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_q_valid", 32'(q_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_q_owner", 32'(q_owner), 32'h0);
        req   = 4'b0000;
        reset = 1'b1;
        tick();

        // rotation from ptr=0
        req = 4'b1111;
        push_g(4'b0001); push_g(4'b0010); push_g(4'b0100);
        push_g(4'b1000); push_g(4'b0001);
        push_w(8'h11, 2'd0); push_w(8'h22, 2'd1); push_w(8'h33, 2'd2);
        push_w(8'h44, 2'd3); push_w(8'h11, 2'd0);
        for (int i = 0; i < 5; i++) tick();
        req = 4'b0000;
        tick();
        chk("rot_end_busy", 32'(busy), 32'h0);

        // single write, ptr now 1
        wdata[23:16] = 8'hA5;
        req = 4'b0100;
        push_g(4'b0100);
        push_w(8'hA5, 2'd2);
        tick();
        req = 4'b0000;
        tick();
        chk("single_busy", 32'(busy), 32'h0);
        chk("single_gnt_off", 32'(gnt), 32'h0);
        chk("single_q", 32'(q), 32'hA5);

        // fairness after ptr moves past 2
        req = 4'b0100;
        push_g(4'b0100); push_g(4'b0001); push_g(4'b0100);
        push_w(8'hA5, 2'd2); push_w(8'h11, 2'd0); push_w(8'hA5, 2'd2);
        tick();
        req = 4'b0101;
        tick();
        tick();
        req = 4'b0000;
        tick();

        // clear colliding with a grant
        wdata[15:8] = 8'h3C;
        req = 4'b0010;
        push_g(4'b0010);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_q", 32'(q), 32'h0);
        chk("clr_q_valid", 32'(q_valid), 32'h0);
        chk("clr_gnt", 32'(gnt), 32'h0);
        chk("clr_busy", 32'(busy), 32'h0);
        push_g(4'b0010);
        push_w(8'h3C, 2'd1);
        tick();
        req = 4'b0000;
        tick();

        // held request alternates GRANT / IDLE
        wdata[15:8] = 8'h5A;
        req = 4'b0010;
        push_g(4'b0010); push_g(4'b0010);
        push_w(8'h5A, 2'd1); push_w(8'h6B, 2'd1);
        tick();
        tick();
        wdata[15:8] = 8'h6B;
        chk("held_gap_gnt", 32'(gnt), 32'h0);
        chk("held_gap_busy", 32'(busy), 32'h0);
        tick();
        tick();
        req = 4'b0000;
        tick();

        // asynchronous reset in the middle of a grant
        req = 4'b1000;
        tick();
        chk("pre_rst_gnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        #2;
        reset = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_q", 32'(q), 32'h0);
        chk("async_q_valid", 32'(q_valid), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        tick();

        chk("gnt_queue_left", 32'(exp_gnt.size()), 32'h0);
        chk("wr_queue_left", 32'(exp_wr.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
